// File: rtl/stage_controller.sv
// rtl/stage_controller.sv - multi-cycle IF/ID/EX/MEM/WB sequencer for the NPC core
// Moore-decoded enables (except irWriteEnable), retired-instruction counter and fetch/data watchdog.
module stage_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemReady,
  input  logic        dmemReady,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic        isEbreak,
  input  logic        isEcall,
  input  logic        writesRd,
  output logic [2:0]  stage,
  output logic        imemReq,
  output logic        irWriteEnable,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic        regWriteEnable,
  output logic        pcWriteEnable,
  output logic        ecallEnable,
  output logic        halt,
  output logic        memTimeout,
  output logic [63:0] retireCount
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5,
    ST_RST  = 3'd7
  } state_t;

  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      next_state;
  logic        load_flag;
  logic        store_flag;
  logic        ebreak_flag;
  logic        ecall_flag;
  logic        writes_rd_flag;
  logic [31:0] wait_cnt;
  logic        waiting;
  logic        timeout_fire;

  // A ready in the limit cycle takes precedence because waiting is then low.
  assign waiting      = ((state == ST_IF) && !imemReady) || ((state == ST_MEM) && !dmemReady);
  assign timeout_fire = waiting && (LIMIT != 32'd0) && (wait_cnt == LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    stage          = state;
    imemReq        = 1'b0;
    irWriteEnable  = 1'b0;
    memReadEnable  = 1'b0;
    memWriteEnable = 1'b0;
    regWriteEnable = 1'b0;
    pcWriteEnable  = 1'b0;
    ecallEnable    = 1'b0;
    halt           = 1'b0;
    case (state)
      ST_RST: next_state = ST_IF;
      ST_IF: begin
        imemReq       = 1'b1;
        irWriteEnable = imemReady;
        if (imemReady) begin
          next_state = ST_ID;
        end else if (timeout_fire) begin
          next_state = ST_HALT;
        end
      end
      ST_ID: next_state = ST_EX;
      ST_EX: begin
        ecallEnable = ecall_flag;
        if (ebreak_flag) begin
          next_state = ST_HALT;
        end else if (load_flag || store_flag) begin
          next_state = ST_MEM;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_MEM: begin
        memReadEnable  = load_flag;
        memWriteEnable = store_flag;
        if (dmemReady) begin
          next_state = ST_WB;
        end else if (timeout_fire) begin
          next_state = ST_HALT;
        end
      end
      ST_WB: begin
        pcWriteEnable  = 1'b1;
        regWriteEnable = writes_rd_flag && !store_flag;
        next_state     = ST_IF;
      end
      ST_HALT: halt = 1'b1;
      default: next_state = ST_IF;
    endcase
  end

  // Decode flags captured at the closing edge of ID; load wins over store.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_flag      <= 1'b0;
      store_flag     <= 1'b0;
      ebreak_flag    <= 1'b0;
      ecall_flag     <= 1'b0;
      writes_rd_flag <= 1'b0;
    end else if (state == ST_ID) begin
      load_flag      <= isLoad;
      store_flag     <= isStore && !isLoad;
      ebreak_flag    <= isEbreak;
      ecall_flag     <= isEcall;
      writes_rd_flag <= writesRd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt    <= 32'd0;
      retireCount <= 64'd0;
      memTimeout  <= 1'b0;
    end else begin
      if (next_state != state) begin
        wait_cnt <= 32'd0;
      end else if (waiting && (LIMIT != 32'd0)) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
      if (state == ST_WB) begin
        retireCount <= retireCount + 64'd1;
      end
      if (timeout_fire) begin
        memTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage_controller.sv
// tb/tb_stage_controller.sv - scoreboard bench for stage_controller
// Stimulus pushes per-cycle expected outputs; a negedge monitor pops and compares.
module tb_stage_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imemReady = 1'b0;
  logic        dmemReady = 1'b0;
  logic        isLoad = 1'b0;
  logic        isStore = 1'b0;
  logic        isEbreak = 1'b0;
  logic        isEcall = 1'b0;
  logic        writesRd = 1'b0;
  logic [2:0]  stage;
  logic        imemReq, irWriteEnable, memReadEnable, memWriteEnable;
  logic        regWriteEnable, pcWriteEnable, ecallEnable, halt, memTimeout;
  logic [63:0] retireCount;

  stage_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .imemReady(imemReady), .dmemReady(dmemReady),
    .isLoad(isLoad), .isStore(isStore), .isEbreak(isEbreak), .isEcall(isEcall),
    .writesRd(writesRd), .stage(stage), .imemReq(imemReq), .irWriteEnable(irWriteEnable),
    .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .regWriteEnable(regWriteEnable), .pcWriteEnable(pcWriteEnable),
    .ecallEnable(ecallEnable), .halt(halt), .memTimeout(memTimeout),
    .retireCount(retireCount)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] I_IR = 7'b1000000;
  localparam logic [6:0] I_DR = 7'b0100000;
  localparam logic [6:0] I_LD = 7'b0010000;
  localparam logic [6:0] I_ST = 7'b0001000;
  localparam logic [6:0] I_EB = 7'b0000100;
  localparam logic [6:0] I_EC = 7'b0000010;
  localparam logic [6:0] I_WR = 7'b0000001;

  localparam logic [8:0] F_IREQ  = 9'b100000000;
  localparam logic [8:0] F_IRWE  = 9'b010000000;
  localparam logic [8:0] F_RD    = 9'b001000000;
  localparam logic [8:0] F_WR    = 9'b000100000;
  localparam logic [8:0] F_RWE   = 9'b000010000;
  localparam logic [8:0] F_PCWE  = 9'b000001000;
  localparam logic [8:0] F_ECALL = 9'b000000100;
  localparam logic [8:0] F_HALT  = 9'b000000010;
  localparam logic [8:0] F_TO    = 9'b000000001;
  localparam logic [8:0] F_FETCH = F_IREQ | F_IRWE;

  typedef struct {
    logic [75:0] vec;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc_idx = 0;

  task automatic cyc(input logic r, input logic [6:0] in, input logic [2:0] es,
                     input logic [8:0] ef, input logic [63:0] er);
    exp_t e;
    @(posedge clock);
    #1;
    reset = r;
    {imemReady, dmemReady, isLoad, isStore, isEbreak, isEcall, writesRd} = in;
    e.vec = {es, ef, er};
    e.cyc = cyc_idx;
    exp_q.push_back(e);
    cyc_idx++;
  endtask

  always @(negedge clock) begin
    logic [75:0] got;
    exp_t        e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {stage, imemReq, irWriteEnable, memReadEnable, memWriteEnable, regWriteEnable,
             pcWriteEnable, ecallEnable, halt, memTimeout, retireCount};
      n_checks++;
      if (got === e.vec) begin
        n_pass++;
      end else begin
        $display("FAIL cycle%0d: got stage=%0d flags=%b retire=%0d, expected stage=%0d flags=%b retire=%0d",
                 e.cyc, got[75:73], got[72:64], got[63:0], e.vec[75:73], e.vec[72:64], e.vec[63:0]);
      end
    end
  end

  initial begin
    // ALU op with rd write: 7,0,1,2,4
    cyc(1, 0, 7, 0, 0);
    cyc(0, 0, 7, 0, 0);
    cyc(0, I_IR, 0, F_FETCH, 0);
    cyc(0, I_WR, 1, 0, 0);
    cyc(0, 0, 2, 0, 0);
    cyc(0, 0, 4, F_PCWE | F_RWE, 0);
    // load, dmemReady after 3 wait cycles
    cyc(0, I_IR, 0, F_FETCH, 1);
    cyc(0, I_LD | I_WR, 1, 0, 1);
    cyc(0, 0, 2, 0, 1);
    cyc(0, 0, 3, F_RD, 1);
    cyc(0, 0, 3, F_RD, 1);
    cyc(0, 0, 3, F_RD, 1);
    cyc(0, I_DR, 3, F_RD, 1);
    cyc(0, 0, 4, F_PCWE | F_RWE, 1);
    // store with writesRd: no register write
    cyc(0, I_IR, 0, F_FETCH, 2);
    cyc(0, I_ST | I_WR, 1, 0, 2);
    cyc(0, 0, 2, 0, 2);
    cyc(0, 0, 3, F_WR, 2);
    cyc(0, I_DR, 3, F_WR, 2);
    cyc(0, 0, 4, F_PCWE, 2);
    // load and store together behave as a load
    cyc(0, I_IR, 0, F_FETCH, 3);
    cyc(0, I_LD | I_ST | I_WR, 1, 0, 3);
    cyc(0, 0, 2, 0, 3);
    cyc(0, I_DR, 3, F_RD, 3);
    cyc(0, 0, 4, F_PCWE | F_RWE, 3);
    // ecall then ebreak
    cyc(0, I_IR, 0, F_FETCH, 4);
    cyc(0, I_EC, 1, 0, 4);
    cyc(0, 0, 2, F_ECALL, 4);
    cyc(0, 0, 4, F_PCWE, 4);
    cyc(0, I_IR, 0, F_FETCH, 5);
    cyc(0, I_EB | I_WR, 1, 0, 5);
    cyc(0, 0, 2, 0, 5);
    cyc(0, 0, 5, F_HALT, 5);
    cyc(0, 7'h7f, 5, F_HALT, 5);
    cyc(0, 7'h7f, 5, F_HALT, 5);
    // watchdog expiry in IF, reset applied from HALT
    cyc(1, 0, 7, 0, 0);
    cyc(0, 0, 7, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, F_IREQ, 0);
    cyc(0, 0, 5, F_HALT | F_TO, 0);
    cyc(0, 0, 5, F_HALT | F_TO, 0);
    // ready on the 4th IF cycle
    cyc(1, 0, 7, 0, 0);
    cyc(0, 0, 7, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, F_IREQ, 0);
    cyc(0, I_IR, 0, F_FETCH, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 2, 0, 0);
    cyc(0, 0, 4, F_PCWE, 0);
    // ready in the limit cycle wins, then reset mid-MEM
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, F_IREQ, 1);
    cyc(0, I_IR, 0, F_FETCH, 1);
    cyc(0, I_LD | I_WR, 1, 0, 1);
    cyc(0, 0, 2, 0, 1);
    cyc(0, 0, 3, F_RD, 1);
    cyc(0, 0, 3, F_RD, 1);
    cyc(1, 0, 7, 0, 0);
    cyc(0, 0, 7, 0, 0);
    cyc(0, I_IR, 0, F_FETCH, 0);
    cyc(0, 0, 1, 0, 0);

    for (int k = 0; k < 4; k++) begin
      if (exp_q.size() > 0) begin
        @(negedge clock);
        #1;
      end
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
